// File: rtl/key_event_ctrl_if.sv
// Event stream between the key event controller and the UI/mode-control consumer.
interface key_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       evt_drop;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_type,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_type,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/key_event_ctrl.sv
// Key event controller: classifies short/long/repeat presses on four debounced
// keys and merges them through a round-robin arbiter into one valid/ready stream.
module key_event_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [3:0]              key_flag,
    input  logic [3:0]              key_state,
    key_event_ctrl_if.master        evt
);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} key_st_t;
    typedef enum logic [1:0] {
        EVT_NONE   = 2'b00,
        EVT_SHORT  = 2'b01,
        EVT_LONG   = 2'b10,
        EVT_REPEAT = 2'b11
    } evt_t;

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       press;
    logic [3:0]       rel;

    key_st_t          state    [4];
    key_st_t          state_nx [4];
    logic [15:0]      ms_cnt   [4];
    logic [15:0]      ms_cnt_nx[4];
    logic [3:0]       post;
    evt_t             post_type[4];

    logic [3:0]       pend;
    evt_t             ptype[4];
    logic [1:0]       rr_ptr;
    logic             slot_free;
    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       search_idx;
    logic [3:0]       grant_oh;

    assign tick  = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign press = key_flag & ~key_state;
    assign rel   = key_flag &  key_state;

    // Free-running 1 ms time-base divider.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Per-key state and millisecond counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i]  <= ST_IDLE;
                ms_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i]  <= state_nx[i];
                ms_cnt[i] <= ms_cnt_nx[i];
            end
        end
    end

    // Per-key next state and event posting; release takes priority over tick.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_nx[i]  = state[i];
            ms_cnt_nx[i] = ms_cnt[i];
            post[i]      = 1'b0;
            post_type[i] = EVT_NONE;
            case (state[i])
                ST_IDLE: begin
                    if (press[i]) begin
                        state_nx[i]  = ST_PRESSED;
                        ms_cnt_nx[i] = '0;
                    end
                end
                ST_PRESSED: begin
                    if (rel[i]) begin
                        post[i]      = 1'b1;
                        post_type[i] = EVT_SHORT;
                        state_nx[i]  = ST_IDLE;
                        ms_cnt_nx[i] = '0;
                    end else if (tick) begin
                        if (ms_cnt[i] + 16'd1 == 16'(LONG_MS)) begin
                            post[i]      = 1'b1;
                            post_type[i] = EVT_LONG;
                            state_nx[i]  = ST_HELD;
                            ms_cnt_nx[i] = '0;
                        end else begin
                            ms_cnt_nx[i] = ms_cnt[i] + 16'd1;
                        end
                    end
                end
                ST_HELD: begin
                    if (rel[i]) begin
                        state_nx[i]  = ST_IDLE;
                        ms_cnt_nx[i] = '0;
                    end else if (tick) begin
                        if (ms_cnt[i] + 16'd1 == 16'(REPEAT_MS)) begin
                            post[i]      = 1'b1;
                            post_type[i] = EVT_REPEAT;
                            ms_cnt_nx[i] = '0;
                        end else begin
                            ms_cnt_nx[i] = ms_cnt[i] + 16'd1;
                        end
                    end
                end
                default: begin
                    state_nx[i]  = ST_IDLE;
                    ms_cnt_nx[i] = '0;
                end
            endcase
        end
    end

    // Round-robin search starting just after the last granted key.
    always_comb begin
        slot_free  = !evt.evt_valid || evt.evt_ready;
        grant_any  = 1'b0;
        grant_idx  = rr_ptr;
        grant_oh   = '0;
        search_idx = rr_ptr;
        if (slot_free) begin
            for (int unsigned k = 1; k <= 4; k++) begin
                search_idx = rr_ptr + 2'(k);
                if (!grant_any && pend[search_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = search_idx;
                end
            end
        end
        grant_oh[grant_idx] = grant_any;
    end

    // Pending slots; a same-cycle post wins over the grant clear and is not a drop.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend         <= '0;
            evt.evt_drop <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) ptype[i] <= EVT_NONE;
        end else begin
            evt.evt_drop <= |(post & pend & ~grant_oh);
            for (int unsigned i = 0; i < 4; i++) begin
                if (post[i]) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= post_type[i];
                end else if (grant_oh[i]) begin
                    pend[i]  <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            evt.evt_valid <= 1'b0;
            evt.evt_key   <= '0;
            evt.evt_type  <= '0;
            rr_ptr        <= 2'd3;
        end else if (slot_free) begin
            if (grant_any) begin
                evt.evt_valid <= 1'b1;
                evt.evt_key   <= grant_idx;
                evt.evt_type  <= ptype[grant_idx];
                rr_ptr        <= grant_idx;
            end else begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: a tick-counting reference model posts
// expected events into a queue, a negedge monitor checks the DUT stream.
module tb_key_event_ctrl;

    localparam int unsigned TICK_DIV  = 10;
    localparam int unsigned LONG_MS   = 5;
    localparam int unsigned REPEAT_MS = 3;

    typedef struct packed {
        logic [1:0] key;
        logic [1:0] typ;
    } ev_t;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic [3:0] key_flag  = '0;
    logic [3:0] key_state = '1;

    key_event_ctrl_if bus();

    key_event_ctrl #(
        .TICK_DIV (TICK_DIV),
        .LONG_MS  (LONG_MS),
        .REPEAT_MS(REPEAT_MS)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .key_flag (key_flag),
        .key_state(key_state),
        .evt      (bus)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];

    // reference model state
    int unsigned m_cycle;
    bit          m_held [4];
    int unsigned m_ticks[4];
    bit          m_pend [4];
    logic [1:0]  m_ptype[4];
    int          m_ptr;
    bit          m_valid;
    bit          m_drop;

    // monitor state
    int          acc_cnt      = 0;
    int          dut_drop_cnt = 0;
    bit          stall_prev   = 0;
    logic [1:0]  prev_key;
    logic [1:0]  prev_type;

    // Reference model: hold time measured in ticks seen since the press.
    always @(posedge Clk or negedge Rst_n) begin : model
        bit         tk;
        bit         post[4];
        logic [1:0] ptyp[4];
        int         g;
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_held[i] = 0; m_ticks[i] = 0; m_pend[i] = 0; m_ptype[i] = 2'b00;
            end
            m_ptr = 3; m_valid = 0; m_drop = 0; m_cycle = 0;
            exp_q.delete();
        end else begin
            tk = (m_cycle % TICK_DIV) == TICK_DIV - 1;
            for (int i = 0; i < 4; i++) begin
                post[i] = 0;
                ptyp[i] = 2'b00;
                if (m_held[i]) begin
                    if (key_flag[i] && key_state[i]) begin
                        if (m_ticks[i] < LONG_MS) begin
                            post[i] = 1; ptyp[i] = 2'b01;
                        end
                        m_held[i] = 0;
                    end else if (tk) begin
                        m_ticks[i]++;
                        if (m_ticks[i] == LONG_MS) begin
                            post[i] = 1; ptyp[i] = 2'b10;
                        end else if (m_ticks[i] > LONG_MS &&
                                     (m_ticks[i] - LONG_MS) % REPEAT_MS == 0) begin
                            post[i] = 1; ptyp[i] = 2'b11;
                        end
                    end
                end else if (key_flag[i] && !key_state[i]) begin
                    m_held[i]  = 1;
                    m_ticks[i] = 0;
                end
            end
            g = -1;
            if (!m_valid || bus.evt_ready) begin
                for (int k = 1; k <= 4; k++)
                    if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                if (g >= 0) begin
                    exp_q.push_back({2'(g), m_ptype[g]});
                    m_valid = 1;
                    m_ptr   = g;
                end else begin
                    m_valid = 0;
                end
            end
            m_drop = 0;
            for (int i = 0; i < 4; i++) begin
                if (post[i]) begin
                    if (m_pend[i] && i != g) m_drop = 1;
                    m_pend[i]  = 1;
                    m_ptype[i] = ptyp[i];
                end else if (i == g) begin
                    m_pend[i] = 0;
                end
            end
            m_cycle++;
        end
    end

    // Monitor: compares the DUT stream against the model away from the clock edge.
    always @(negedge Clk) begin : monitor
        ev_t e;
        if (!Rst_n) begin
            stall_prev = 0;
        end else begin
            checks++;
            if (bus.evt_valid !== m_valid) begin
                errors++;
                $display("FAIL evt_valid: got %b expected %b at %0t", bus.evt_valid, m_valid, $time);
            end
            checks++;
            if (bus.evt_drop !== m_drop) begin
                errors++;
                $display("FAIL evt_drop: got %b expected %b at %0t", bus.evt_drop, m_drop, $time);
            end
            if (bus.evt_drop === 1'b1) dut_drop_cnt++;
            if (stall_prev) begin
                checks++;
                if (bus.evt_key !== prev_key || bus.evt_type !== prev_type) begin
                    errors++;
                    $display("FAIL hold_stable: got key %0d type %b expected key %0d type %b at %0t",
                             bus.evt_key, bus.evt_type, prev_key, prev_type, $time);
                end
            end
            if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
                acc_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got key %0d type %b expected none at %0t",
                             bus.evt_key, bus.evt_type, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.evt_key !== e.key || bus.evt_type !== e.typ) begin
                        errors++;
                        $display("FAIL event: got key %0d type %b expected key %0d type %b at %0t",
                                 bus.evt_key, bus.evt_type, e.key, e.typ, $time);
                    end
                end
            end
            stall_prev = (bus.evt_valid === 1'b1) && (bus.evt_ready === 1'b0);
            prev_key   = bus.evt_key;
            prev_type  = bus.evt_type;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #2;
            key_flag = '0;
        end
    endtask

    task automatic kedge(input logic [3:0] mask, input bit pressed);
        step();
        key_flag = mask;
        for (int i = 0; i < 4; i++)
            if (mask[i]) key_state[i] = pressed ? 1'b0 : 1'b1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin : stimulus
        int a0;
        int d0;
        bus.evt_ready = 1'b1;
        #12;
        check_val("reset_valid", int'(bus.evt_valid), 0);
        check_val("reset_drop",  int'(bus.evt_drop),  0);
        check_val("reset_key",   int'(bus.evt_key),   0);
        check_val("reset_type",  int'(bus.evt_type),  0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step(3);

        // short press on key 1
        a0 = acc_cnt;
        kedge(4'b0010, 1);
        step(30);
        kedge(4'b0010, 0);
        step(10);
        check_val("short_count", acc_cnt - a0, 1);

        // long press with repeats on key 2
        a0 = acc_cnt;
        kedge(4'b0100, 1);
        step(150);
        kedge(4'b0100, 0);
        step(10);
        check_val("long_count", acc_cnt - a0, 4);

        // simultaneous bursts under backpressure
        for (int b = 0; b < 2; b++) begin
            a0 = acc_cnt;
            bus.evt_ready = 1'b0;
            kedge(4'b1011, 1);
            step(5);
            kedge(4'b1011, 0);
            step(20);
            bus.evt_ready = 1'b1;
            step(10);
            check_val("burst_count", acc_cnt - a0, 3);
        end

        // overwrite: key 3 occupies the slot, key 0 LONG then REPEAT collide
        d0 = dut_drop_cnt;
        bus.evt_ready = 1'b0;
        kedge(4'b1000, 1);
        step(5);
        kedge(4'b1000, 0);
        step(3);
        kedge(4'b0001, 1);
        step(85);
        kedge(4'b0001, 0);
        step(5);
        check_val("overwrite_drops", dut_drop_cnt - d0, 1);
        bus.evt_ready = 1'b1;
        step(10);

        // reset while key 2 is held with an event pending
        bus.evt_ready = 1'b0;
        kedge(4'b0100, 1);
        step(90);
        #1;
        Rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", int'(bus.evt_valid), 0);
        check_val("rst_mid_drop",  int'(bus.evt_drop),  0);
        check_val("rst_mid_key",   int'(bus.evt_key),   0);
        check_val("rst_mid_type",  int'(bus.evt_type),  0);
        bus.evt_ready = 1'b1;
        step(3);
        @(negedge Clk);
        Rst_n = 1'b1;
        a0 = acc_cnt;
        step(60);
        kedge(4'b0100, 0);
        step(20);
        check_val("post_reset_quiet", acc_cnt - a0, 0);

        // randomized key activity and backpressure
        for (int c = 0; c < 5000; c++) begin
            step();
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 79) == 0) begin
                    key_flag[i]  = 1'b1;
                    key_state[i] = ~key_state[i];
                end else if ($urandom_range(0, 199) == 0) begin
                    key_flag[i]  = 1'b1;
                end
            end
        end

        // drain
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            if (key_state[i] == 1'b0) kedge(4'(1 << i), 0);
        step(30);
        check_val("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
